// File: rtl/sram_data_controller.sv
// -----------------------------------------------------------------------------
// sram_data_controller
//
// Splits one 32-bit MEM-stage load or store into two timed 16-bit accesses to
// an external asynchronous SRAM (low half-word first, then high half-word).
// It stalls the pipeline with `freeze` while an access is in flight. A load
// result is presented with a single-cycle `ready` pulse.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   rd_en        load request from the MEM stage
//   wr_en        store request from the MEM stage (wins if rd_en is also high)
//   address      byte address (ALU result); BASE_ADDR maps to SRAM word 0
//   write_data   store data
//   read_data    assembled load result (held until the next load)
//   ready        one-cycle completion pulse (DONE state)
//   freeze       pipeline stall, combinational
//   sram_addr    18-bit half-word address
//   sram_dq_in   SRAM read data
//   sram_dq_out  SRAM write data
//   sram_dq_oe   data bus drive enable (the tristate is built above this block)
//   sram_we_n    write strobe, active-low
//   sram_oe_n    output enable, active-low
//   dbg_state    current FSM state, for observation only
//
// Handshake: a request (rd_en | wr_en) is accepted in the IDLE cycle where it
// is first seen. `freeze` goes high in that same cycle and stays high until the
// cycle before DONE. `ready` is high in DONE only. The pipeline advances on
// the edge that ends DONE, and the next request is looked at one cycle later
// in IDLE. No abort is possible once a request has been accepted.
// -----------------------------------------------------------------------------
module sram_data_controller #(
  parameter int WAIT_CYCLES = 2,
  parameter int BASE_ADDR   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        freeze,
  output logic [17:0] sram_addr,
  input  logic [15:0] sram_dq_in,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  output logic        sram_we_n,
  output logic        sram_oe_n,
  output logic [1:0]  dbg_state
);

  // A single-cycle phase still needs a one-bit counter.
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [31:0]      BASE_U   = 32'(BASE_ADDR);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              op_wr_q, op_wr_d;
  logic [16:0]       word_q, word_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       read_data_q, read_data_d;

  logic              request;
  logic              cnt_last;
  logic              in_phase;
  logic [16:0]       offset_word;

  assign request  = rd_en | wr_en;
  assign cnt_last = (cnt_q == CNT_LAST);
  assign in_phase = (state_q == S_LOW) || (state_q == S_HIGH);

  // The byte offset wraps modulo 2^32. Bits [1:0] select a byte inside the
  // word and are dropped. Bits above 18 fall outside the SRAM and are dropped
  // as well, so an out-of-range address wraps silently.
  assign offset_word = 17'((address - BASE_U) >> 2);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_wr_q     <= 1'b0;
      word_q      <= '0;
      wdata_q     <= '0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_wr_q     <= op_wr_d;
      word_q      <= word_d;
      wdata_q     <= wdata_d;
      read_data_q <= read_data_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_wr_d     = op_wr_q;
    word_d      = word_q;
    wdata_d     = wdata_q;
    read_data_d = read_data_q;

    case (state_q)
      S_IDLE: begin
        if (request) begin
          // A write takes priority when both enables are high.
          op_wr_d = wr_en;
          word_d  = offset_word;
          wdata_d = write_data;
          cnt_d   = '0;
          state_d = S_LOW;
        end
      end

      S_LOW: begin
        if (cnt_last) begin
          // Sample the SRAM at the end of the phase, after it has had the
          // full WAIT_CYCLES of access time.
          if (!op_wr_q) begin
            read_data_d[15:0] = sram_dq_in;
          end
          cnt_d   = '0;
          state_d = S_HIGH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_HIGH: begin
        if (cnt_last) begin
          if (!op_wr_q) begin
            read_data_d[31:16] = sram_dq_in;
          end
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // SRAM-side outputs and ready are decoded from registered state only.
  // This keeps the request inputs off every path that reaches the SRAM pins.
  always_comb begin
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    sram_oe_n   = 1'b1;

    if (in_phase) begin
      sram_addr = {word_q, (state_q == S_HIGH)};
      if (op_wr_q) begin
        sram_we_n   = 1'b0;
        sram_dq_oe  = 1'b1;
        sram_dq_out = (state_q == S_HIGH) ? wdata_q[31:16] : wdata_q[15:0];
      end else begin
        sram_oe_n = 1'b0;
      end
    end
  end

  assign ready     = (state_q == S_DONE);
  assign freeze    = ((state_q == S_IDLE) && request) || in_phase;
  assign read_data = read_data_q;
  assign dbg_state = state_q;

endmodule

// File: doc/sram_data_controller.md
# sram_data_controller

Sequencer between the MEM stage of the ARM pipeline and an external 16-bit asynchronous SRAM that holds data memory. It turns one 32-bit load or store into two timed 16-bit SRAM half-word accesses. While the access is in flight it raises `freeze` to stall the pipeline stage registers. It presents the assembled 32-bit load result with a one-cycle `ready` pulse.

## Interface
- `WAIT_CYCLES`, default 2: cycles each SRAM half access is held; valid range is 1 or more.
- `BASE_ADDR`, default 1024: byte address that maps to SRAM word 0.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; one clock, asynchronous, active-low.
- `rd_en`  in  1  MEM-stage load request.
- `wr_en`  in  1  MEM-stage store request.
- `address`  in  32  byte address from the EXE/MEM register (ALU result).
- `write_data`  in  32  store data (Rm value).
- `read_data`  out  32  load result.
- `ready`  out  1  one-cycle completion pulse.
- `freeze`  out  1  pipeline stall; drives the `freeze` of all stage registers and the PC.
- `sram_addr`  out  18  half-word address.
- `sram_dq_in`  in  16  SRAM read data.
- `sram_dq_out`  out  16  SRAM write data.
- `sram_dq_oe`  out  1  data-bus output enable. The top level builds the tristate from it.
- `sram_we_n`  out  1  write strobe, active-low.
- `sram_oe_n`  out  1  output enable, active-low.

## Operation
- Requests:
  - Request = `rd_en | wr_en`.
  - If both are high, the access is a write.
- States: IDLE, LOW, HIGH, DONE.
- IDLE:
  - With a request: latch the op (read or write), `address`, and `write_data`. Clear the wait counter and go to LOW.
  - With no request: stay in IDLE.
- Address arithmetic:
  - `offset = address - BASE_ADDR`, computed mod 2^32.
  - `word = offset[18:2]`; `offset[1:0]` is ignored.
  - Address out of range wraps silently.
  - LOW drives `sram_addr = {word, 1'b0}`. HIGH drives `{word, 1'b1}`.
- LOW and HIGH phases:
  - Each phase lasts exactly WAIT_CYCLES cycles, counted by a counter from 0 to WAIT_CYCLES-1.
  - `sram_addr` is stable for the whole phase.
  - On a read, `sram_oe_n` is 0 and `sram_we_n` is 1. On the last cycle of the phase, `sram_dq_in` is registered into `read_data[15:0]` (LOW) or `read_data[31:16]` (HIGH).
  - On a write, `sram_we_n` is 0, `sram_oe_n` is 1 and `sram_dq_oe` is 1. `sram_dq_out` carries the latched data, bits [15:0] in LOW and bits [31:16] in HIGH.
  - On the last cycle, LOW goes to HIGH and HIGH goes to DONE.
- DONE: `ready` is 1 and all strobes are inactive. Next state is always IDLE.
- `freeze` is combinational: `(state==IDLE & request) | state==LOW | state==HIGH`.
- Input stability:
  - The latched copies of the request are used throughout the access.
  - Input changes after IDLE have no effect, and the access always completes; there is no abort.
- `read_data`:
  - Holds its value after DONE until the next read overwrites it.
  - Writes never change it.
  - During a read, bits [15:0] update at the end of LOW, ahead of bits [31:16]. The value is valid for the pipeline only in the DONE cycle.

## Timing
- Reset (asynchronous, `rst`=0):
  - State goes to IDLE and the counter to 0.
  - `read_data`=0, `ready`=0, `sram_addr`=0, `sram_dq_out`=0, `sram_dq_oe`=0, `sram_we_n`=1, `sram_oe_n`=1.
  - `freeze`=0 unless a request is present; it is combinational.
- Reset mid-access: the access is abandoned immediately, strobes are released, and nothing is retried.
- Latency, with the request first seen in IDLE at cycle t:
  - LOW occupies t+1 to t+W.
  - HIGH occupies t+W+1 to t+2W.
  - DONE is at t+2W+1.
  - `freeze` is high for 2W+1 cycles, t to t+2W.
- The pipeline advances on the clock edge that ends DONE. The next instruction's request is evaluated in IDLE at t+2W+2.
- Back-to-back accesses cost 2W+2 cycles each, with one IDLE cycle between them.
- All SRAM-side outputs and `ready` are registered or decoded from registered state only, so they carry no combinational path from the request inputs.

## Test plan
- Reset with no request: check the reset values above. `freeze`=0 and `sram_we_n`=1.
- Read with W=2, `address`=1032, and the SRAM model holding half-words 4 = 0xBEEF and 5 = 0xDEAD:
  - `sram_addr` is 4 for 2 cycles, then 5 for 2 cycles.
  - `freeze` is high for 5 cycles.
  - `ready` pulses at t+5 with `read_data`=0xDEADBEEF.
- Write with W=2, `address`=1024, `write_data`=0x12345678:
  - Half-word 0 is written with 0x5678 and half-word 1 with 0x1234.
  - `sram_we_n` is low for 4 cycles and `sram_dq_oe` follows it.
  - `read_data` is unchanged.
- Write 0xCAFEF00D to 1028, then read 1028: the read returns 0xCAFEF00D, with exactly one IDLE cycle between the two accesses.
- `rd_en` and `wr_en` both high: a write is performed. With `address`=1020, offset 0xFFFFFFFC wraps to `sram_addr` {word 0x1FFFF, half}, i.e. half-word addresses 0x3FFFE and 0x3FFFF.
- `rst` asserted during HIGH of a read: the same cycle yields IDLE, `sram_oe_n`=1, `read_data`=0, and no `ready` pulse. After release, a new read completes normally.
